host_wb_bridge: RTL
===================

Name: host_wb_bridge

Overview:
- Downstream consumer of the FT245 host interface.
- Turns decoded host transactions (ping/write/read) into Wishbone classic master cycles.
- Returns responses through the host interface's outgoing-data handshake.
- Sits between the FT host interface and the Wishbone interconnect; one transaction in flight at a time.

Parameters:
ADDR_INC, 1, value added to the bus address after each word
WB_TIMEOUT, 255, cycles stb may stay high without ack before the cycle is abandoned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ih_ready  in  1  one-cycle pulse: in_* fields valid
master_ready  out  1  bridge can accept an ih_ready pulse
in_command  in  32  [3:0]: 0 ping, 1 write, 2 read
in_address  in  32  start word address
in_data_count  in  28  see Behaviour
in_data  in  32  write data word
oh_ready  in  1  host interface can accept oh_en
oh_en  out  1  one-cycle pulse: out_* valid
out_status  out  32  response status
out_address  out  32  echoed start address
out_data_count  out  28  response words minus one
out_data  out  32  response data word
wb_adr_o  out  32  bus address
wb_dat_o  out  32  bus write data
wb_dat_i  in  32  bus read data
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte selects, always 4'hF during a cycle
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  acknowledge

Behaviour:
- Async reset: all outputs 0, state IDLE, counters 0. master_ready rises on the first clk edge after rst falls.
- ih_ready is honoured only when master_ready=1. The cycle it is sampled, master_ready <= 0.
- oh_en is asserted only when oh_ready=1. It is never high two consecutive cycles. out_* stay stable until the next oh_en.
- Status word: out_status = ~in_command (latched). Bit 31 is forced to 0 if a bus timeout occurred before the first oh_en of the response.
- Low nibble of out_status: ping F, write E, read D.
- Write word count: in_data_count at the first ih_ready = number of additional words to follow. Total words = in_data_count + 1.
- Read word count: N = in_data_count, with 0 treated as 1.
- Unknown command nibble: transaction dropped, no response, return to IDLE with master_ready=1.
- States:
  - IDLE: master_ready=1. On ih_ready, latch command/address/count/data.
    - cmd 0 -> RESP
    - cmd 1 -> WB_WR, remaining = in_data_count
    - cmd 2 -> WB_RD, remaining = N-1
  - WB_WR: drive cyc=stb=we=1, sel=F, adr, dat.
    - On ack: drop cyc/stb next edge, adr += ADDR_INC.
    - If remaining=0 -> RESP; else remaining-1, master_ready<=1 -> WR_WAIT.
  - WR_WAIT: on ih_ready, latch in_data only (other in_* ignored), master_ready<=0 -> WB_WR.
  - WB_RD: drive cyc=stb=1, we=0. On ack, out_data <= wb_dat_i -> RD_SEND.
  - RD_SEND: wait for oh_ready, then pulse oh_en.
    - First beat: out_address = start address, out_data_count = N-1, out_status set.
    - If remaining>0: remaining-1, adr += ADDR_INC -> WB_RD. Else -> IDLE.
  - RESP: wait for oh_ready, then pulse oh_en with out_address = start address, out_data_count=0, out_data=0 -> IDLE.
- Timeout: a counter runs while stb=1 and ack=0. On reaching WB_TIMEOUT, drop cyc/stb, set error, continue as if acked.
  - Read: the word reads as 0. After a timeout, remaining read words skip the bus and are sent as 0 so framing holds.
  - Write: remaining words are still collected from the host but not driven on the bus.
- Ack arriving in the same cycle the timeout count is reached counts as ack; error not set.
- Stray wb_ack_i while stb=0: ignored.
- Response fields are frozen at the first oh_en, so a timeout on a later read word does not clear bit 31.
- Reset mid-transaction: bus released immediately (cyc/stb 0), no response sent.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
- Ping (cmd 0, addr 0x1234) with oh_ready=1 -> no wb_cyc_o; one oh_en, out_status=FFFFFFFF, out_data_count=0, out_address=0x1234.
- Write cmd 1, addr 0x10, count 2, data A,B,C pulsed on ih_ready -> three bus writes at 0x10,0x11,0x12 with data A,B,C; master_ready high between words; one oh_en with status FFFFFFFE.
- Read cmd 2, addr 0x20, count 3, slave returns 0x11,0x22,0x33 -> three oh_en beats with out_data 0x11,0x22,0x33; first beat out_data_count=2, status FFFFFFFD.
- Read with oh_ready held low 50 cycles -> oh_en stays 0 and out_data holds; single pulse once oh_ready rises.
- Read count 1, slave never acks -> stb drops after 255 cycles; oh_en with out_data=0, out_status=7FFFFFFD.
- Reset asserted mid-write while cyc high -> cyc/stb/oh_en 0 immediately; master_ready 1 one cycle after release; no response emitted.

Source files
------------

// File: rtl/host_wb_bridge.sv
`default_nettype none
// =====================================================================
// Module   : host_wb_bridge
// Brief    : Turns decoded host ping/write/read transactions into
//            Wishbone classic master cycles and returns host responses.
// Revision : 1.0 - initial release
// =====================================================================
module host_wb_bridge #(
  parameter logic [31:0] ADDR_INC   = 32'd1,
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ih_ready,
  output logic        master_ready,
  input  logic [31:0] in_command,
  input  logic [31:0] in_address,
  input  logic [27:0] in_data_count,
  input  logic [31:0] in_data,
  input  logic        oh_ready,
  output logic        oh_en,
  output logic [31:0] out_status,
  output logic [31:0] out_address,
  output logic [27:0] out_data_count,
  output logic [31:0] out_data,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_WR   = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WB_RD   = 3'd3,
    S_RD_SEND = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam int unsigned            c_TMO_W    = $clog2(WB_TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0]     c_TMO_LAST = c_TMO_W'(WB_TIMEOUT - 1);

  state_t              r_state;
  logic [31:0]         r_cmd;
  logic [31:0]         r_start_addr;
  logic [27:0]         r_remaining;
  logic [27:0]         r_rd_last;
  logic                r_error;
  logic                r_first;
  logic [c_TMO_W-1:0]  r_tmo;

  logic        w_ack;
  logic        w_tmo;
  logic        w_skip;
  logic        w_bus_wait;
  logic [27:0] w_rd_last;
  logic [31:0] w_status;

  // An ack in the final allowed cycle wins over the timeout.
  assign w_ack      = wb_stb_o & wb_ack_i;
  assign w_tmo      = wb_stb_o & ~wb_ack_i & (r_tmo == c_TMO_LAST);
  assign w_skip     = ~wb_stb_o;
  assign w_bus_wait = wb_stb_o & ~wb_ack_i & ~w_tmo;
  assign w_rd_last  = (in_data_count == 28'd0) ? 28'd0 : in_data_count - 28'd1;
  assign w_status   = {~r_cmd[31] & ~r_error, ~r_cmd[30:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      master_ready   <= 1'b0;
      oh_en          <= 1'b0;
      out_status     <= '0;
      out_address    <= '0;
      out_data_count <= '0;
      out_data       <= '0;
      wb_adr_o       <= '0;
      wb_dat_o       <= '0;
      wb_we_o        <= 1'b0;
      wb_sel_o       <= '0;
      wb_stb_o       <= 1'b0;
      wb_cyc_o       <= 1'b0;
      r_cmd          <= '0;
      r_start_addr   <= '0;
      r_remaining    <= '0;
      r_rd_last      <= '0;
      r_error        <= 1'b0;
      r_first        <= 1'b0;
      r_tmo          <= '0;
    end else begin
      oh_en <= 1'b0;
      if (w_bus_wait) r_tmo <= r_tmo + 1'b1;
      else            r_tmo <= '0;

      case (r_state)
        S_IDLE: begin
          master_ready <= 1'b1;
          if (master_ready && ih_ready) begin
            master_ready <= 1'b0;
            r_cmd        <= in_command;
            r_start_addr <= in_address;
            wb_adr_o     <= in_address;
            wb_dat_o     <= in_data;
            r_error      <= 1'b0;
            r_first      <= 1'b1;
            case (in_command[3:0])
              4'd0: r_state <= S_RESP;
              4'd1: begin
                r_remaining <= in_data_count;
                r_state     <= S_WB_WR;
                wb_cyc_o    <= 1'b1;
                wb_stb_o    <= 1'b1;
                wb_we_o     <= 1'b1;
                wb_sel_o    <= 4'hF;
              end
              4'd2: begin
                r_remaining <= w_rd_last;
                r_rd_last   <= w_rd_last;
                r_state     <= S_WB_RD;
                wb_cyc_o    <= 1'b1;
                wb_stb_o    <= 1'b1;
                wb_sel_o    <= 4'hF;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end

        // After a timeout the strobe is never raised, so w_skip completes the word at once.
        S_WB_WR: begin
          if (w_ack || w_tmo || w_skip) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= wb_adr_o + ADDR_INC;
            if (w_tmo) r_error <= 1'b1;
            if (r_remaining == 28'd0) begin
              r_state <= S_RESP;
            end else begin
              r_remaining  <= r_remaining - 28'd1;
              master_ready <= 1'b1;
              r_state      <= S_WR_WAIT;
            end
          end
        end

        S_WR_WAIT: begin
          if (ih_ready) begin
            wb_dat_o     <= in_data;
            master_ready <= 1'b0;
            r_state      <= S_WB_WR;
            if (!r_error) begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_sel_o <= 4'hF;
            end
          end
        end

        S_WB_RD: begin
          if (w_ack || w_tmo || w_skip) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= '0;
            out_data <= w_ack ? wb_dat_i : 32'd0;
            if (w_tmo) r_error <= 1'b1;
            r_state <= S_RD_SEND;
          end
        end

        S_RD_SEND: begin
          if (oh_ready) begin
            oh_en <= 1'b1;
            if (r_first) begin
              r_first        <= 1'b0;
              out_status     <= w_status;
              out_address    <= r_start_addr;
              out_data_count <= r_rd_last;
            end
            if (r_remaining != 28'd0) begin
              r_remaining <= r_remaining - 28'd1;
              wb_adr_o    <= wb_adr_o + ADDR_INC;
              r_state     <= S_WB_RD;
              if (!r_error) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_RESP: begin
          if (oh_ready) begin
            oh_en          <= 1'b1;
            out_status     <= w_status;
            out_address    <= r_start_addr;
            out_data_count <= 28'd0;
            out_data       <= 32'd0;
            r_state        <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
